// File: rtl/control_unit_pkg.sv
// cu_pkg: opcodes, state encoding and datapath select codes
// for the accumulator CPU control unit.
package cu_pkg;

  localparam int OPCODE_WIDTH = 5;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  localparam opcode_t OP_HLT  = 5'h00;
  localparam opcode_t OP_STO  = 5'h01;
  localparam opcode_t OP_LD   = 5'h02;
  localparam opcode_t OP_LDI  = 5'h03;
  localparam opcode_t OP_ADD  = 5'h04;
  localparam opcode_t OP_ADDI = 5'h05;
  localparam opcode_t OP_SUB  = 5'h06;
  localparam opcode_t OP_SUBI = 5'h07;
  localparam opcode_t OP_BEQ  = 5'h08;
  localparam opcode_t OP_BNE  = 5'h09;
  localparam opcode_t OP_BLT  = 5'h0A;
  localparam opcode_t OP_JMP  = 5'h0B;
  localparam opcode_t OP_NOP  = 5'h0C;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } cu_state_e;

  localparam logic [1:0] SEL_A_DATA_MEMORY = 2'b00;
  localparam logic [1:0] SEL_A_EXT         = 2'b01;
  localparam logic [1:0] SEL_A_ULA         = 2'b10;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_EXT = 1'b1;

  localparam logic [1:0] ULA_ADD    = 2'b00;
  localparam logic [1:0] ULA_SUB    = 2'b01;
  localparam logic [1:0] ULA_PASS_B = 2'b10;

  function automatic logic is_mem_op(opcode_t op);
    return op inside {OP_STO, OP_LD, OP_ADD, OP_SUB};
  endfunction

  function automatic logic is_imm_op(opcode_t op);
    return op inside {OP_LDI, OP_ADDI, OP_SUBI};
  endfunction

  function automatic logic is_br_op(opcode_t op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_JMP};
  endfunction

  function automatic logic [1:0] ula_of(opcode_t op);
    return (op == OP_SUB || op == OP_SUBI) ? ULA_SUB : ULA_ADD;
  endfunction

  function automatic logic sel_b_of(opcode_t op);
    return (op == OP_ADDI || op == OP_SUBI) ? SEL_B_EXT : SEL_B_MEM;
  endfunction

  function automatic logic [1:0] sel_a_of(opcode_t op);
    logic [1:0] sel;
    case (op)
      OP_LD:   sel = SEL_A_DATA_MEMORY;
      OP_LDI:  sel = SEL_A_EXT;
      default: sel = SEL_A_ULA;
    endcase
    return sel;
  endfunction

  function automatic logic br_taken(opcode_t op, logic z, logic n);
    logic t;
    case (op)
      OP_BEQ:  t = z;
      OP_BNE:  t = !z;
      OP_BLT:  t = n;
      OP_JMP:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: bundle between the control unit and the
// IR, status flags, datapath and data memory.
interface control_unit_if #(
  parameter int OPCODE_WIDTH = cu_pkg::OPCODE_WIDTH
);

  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero_flag;
  logic                    neg_flag;
  logic                    mem_ready;
  logic                    step;

  logic [1:0]              sel_A;
  logic                    sel_B;
  logic [1:0]              ula_op;
  logic                    a_wr;
  logic                    ir_wr;
  logic                    pc_wr;
  logic                    pc_src;
  logic                    mem_rd;
  logic                    mem_wr;
  logic                    halted;

  modport master (
    input  opcode, zero_flag, neg_flag, mem_ready, step,
    output sel_A, sel_B, ula_op, a_wr, ir_wr,
    output pc_wr, pc_src, mem_rd, mem_wr, halted
  );

  modport slave (
    output opcode, zero_flag, neg_flag, mem_ready, step,
    input  sel_A, sel_B, ula_op, a_wr, ir_wr,
    input  pc_wr, pc_src, mem_rd, mem_wr, halted
  );

endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore FSM for the accumulator CPU.
// Define CU_DEBUG_STEP_EN to gate each fetch on the step input.
module control_unit
  import cu_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  control_unit_if.master cu
);

  cu_state_e  r_state;

  opcode_t    w_op;
  logic       w_go;
  logic [1:0] w_sel_a;
  logic       w_sel_b;
  logic [1:0] w_ula;
  logic       w_a_wr;
  logic       w_ir_wr;
  logic       w_pc_wr;
  logic       w_pc_src;
  logic       w_mem_rd;
  logic       w_mem_wr;
  logic       w_halted;

  assign w_op = cu.opcode;

`ifdef CU_DEBUG_STEP_EN
  assign w_go = cu.step;
`else
  logic w_unused_step;
  assign w_unused_step = cu.step;
  assign w_go = 1'b1;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_go) r_state <= S_DECODE;
        end
        S_DECODE: begin
          unique case (1'b1)
            (w_op == OP_HLT): r_state <= S_HALT;
            is_mem_op(w_op):  r_state <= S_EXEC;
            is_imm_op(w_op):  r_state <= S_EXEC;
            is_br_op(w_op):   r_state <= S_EXEC;
            default:          r_state <= S_FETCH;
          endcase
        end
        S_EXEC: begin
          // Memory ops stall here until the access completes
          unique case (1'b1)
            is_mem_op(w_op): begin
              if (cu.mem_ready) begin
                r_state <= (w_op == OP_STO) ? S_FETCH : S_WB;
              end
            end
            is_imm_op(w_op): r_state <= S_WB;
            default:         r_state <= S_FETCH;
          endcase
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_sel_a  = SEL_A_DATA_MEMORY;
    w_sel_b  = SEL_B_MEM;
    w_ula    = ULA_ADD;
    w_a_wr   = 1'b0;
    w_ir_wr  = 1'b0;
    w_pc_wr  = 1'b0;
    w_pc_src = 1'b0;
    w_mem_rd = 1'b0;
    w_mem_wr = 1'b0;
    w_halted = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        // Reset forces FETCH, so its strobes must be masked by reset
        w_ir_wr = !reset && w_go;
        w_pc_wr = !reset && w_go;
      end
      S_DECODE: begin
      end
      S_EXEC: begin
        w_sel_b = sel_b_of(w_op);
        w_ula   = ula_of(w_op);
        unique case (1'b1)
          is_mem_op(w_op): begin
            w_mem_rd = (w_op != OP_STO);
            w_mem_wr = (w_op == OP_STO);
          end
          is_br_op(w_op): begin
            w_pc_wr  = br_taken(w_op, cu.zero_flag, cu.neg_flag);
            w_pc_src = w_pc_wr;
          end
          default: begin
          end
        endcase
      end
      S_WB: begin
        w_a_wr  = 1'b1;
        w_sel_a = sel_a_of(w_op);
        w_sel_b = sel_b_of(w_op);
        w_ula   = ula_of(w_op);
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cu.sel_A  = w_sel_a;
  assign cu.sel_B  = w_sel_b;
  assign cu.ula_op = w_ula;
  assign cu.a_wr   = w_a_wr;
  assign cu.ir_wr  = w_ir_wr;
  assign cu.pc_wr  = w_pc_wr;
  assign cu.pc_src = w_pc_src;
  assign cu.mem_rd = w_mem_rd;
  assign cu.mem_wr = w_mem_wr;
  assign cu.halted = w_halted;

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle Moore control FSM for the accumulator CPU. It decodes the instruction register opcode and sequences fetch, decode, execute and write-back. It drives the accumulator input-select (`sel_A`), accumulator and memory write strobes, PC control and ULA operation. It sits between the instruction register/status flags and the datapath, handshaking with data memory through `mem_ready`.

## Interface
- `OPCODE_WIDTH`, 5, opcode field width (upper bits of the instruction word).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in `OPCODE_WIDTH`: IR opcode field, stable from DECODE onward.
- `zero_flag` in 1: status Z (accumulator == 0).
- `neg_flag` in 1: status N (accumulator MSB).
- `mem_ready` in 1: data memory access complete this cycle.
- `step` in 1: single-step pulse; used only with `CU_DEBUG_STEP_EN`.
- `sel_A` out 2: accumulator source. 00 data memory, 01 EXT, 10 ULA. 11 is never driven.
- `sel_B` out 1: ULA operand B. 0 data memory, 1 EXT.
- `ula_op` out 2: 00 ADD, 01 SUB, 10 PASS_B.
- `a_wr` out 1: accumulator write enable.
- `ir_wr` out 1: instruction register load.
- `pc_wr` out 1: PC write enable.
- `pc_src` out 1: 0 = PC+1, 1 = EXT branch target.
- `mem_rd` out 1: data memory read request.
- `mem_wr` out 1: data memory write request.
- `halted` out 1: FSM in HALT.

## Operation
- States: FETCH, DECODE, EXEC, WB, HALT. Encoding is a package enum.
- FETCH: assert `ir_wr`, `pc_wr`, `pc_src`=0. Go to DECODE.
- DECODE: all strobes low. Go to EXEC, except HLT goes to HALT and NOP/undefined go to FETCH.
- Opcodes:
  - 00 HLT
  - 01 STO: `mem_wr`
  - 02 LD: `mem_rd`, WB `sel_A`=00
  - 03 LDI: WB `sel_A`=01
  - 04 ADD: `mem_rd`, `sel_B`=0, `ula_op`=00, WB `sel_A`=10
  - 05 ADDI: `sel_B`=1, `ula_op`=00
  - 06 SUB: like ADD with `ula_op`=01
  - 07 SUBI: like ADDI with `ula_op`=01
  - 08 BEQ: taken if Z
  - 09 BNE: taken if !Z
  - 0A BLT: taken if N
  - 0B JMP: always taken
  - 0C NOP
  - All others behave as NOP.
- EXEC, memory opcodes (STO, LD, ADD, SUB): hold `mem_rd`/`mem_wr` and the ULA controls until `mem_ready`=1. Then STO goes to FETCH; the others go to WB.
- EXEC, immediate opcodes (LDI, ADDI, SUBI): one cycle, then WB.
- EXEC, branch: if taken, `pc_wr`=1 and `pc_src`=1. Go to FETCH.
- WB: `a_wr`=1 with `sel_A` per opcode; the ULA controls are held from EXEC. Go to FETCH.
- `sel_A` is 00 in every cycle where `a_wr`=0. This gives the latch-style accumulator mux a defined select at all times.
- HALT: all strobes low, `halted`=1. Only reset exits HALT.
- `mem_rd` and `mem_wr` are never asserted together.

## Timing
- Outputs are a combinational decode of state and opcode (Moore-style). No output registers.
- Latency in cycles with `mem_ready` tied high: immediates 4, LD/ADD/SUB 4, STO 3, branches 3, NOP 2.
- Each cycle of `mem_ready`=0 in EXEC adds one cycle.
- Reset asserted: state goes to FETCH immediately and asynchronously. All outputs go to 0 except the FETCH strobes, which are gated off while `reset`=1.
- First fetch occurs on the first rising edge after `reset` deasserts.
- Reset mid-instruction aborts it. Any pending `mem_wr` drops in the same cycle.
- `mem_ready` is sampled only in EXEC of a memory opcode and ignored elsewhere.

## Configuration
- `CU_DEBUG_STEP_EN` defined: FETCH is entered only on a rising edge where `step`=1. Otherwise the FSM waits in FETCH with all strobes low. One instruction executes per `step` pulse.
- Undefined: `step` is ignored and FETCH proceeds every time it is entered.

## Structure
- Package `cu_pkg` holds:
  - opcode constants
  - state enum
  - `sel_A` constants (`_DATA_MEMORY`=00, `_EXT`=01, `_ULA`=10)
  - `ula_op` constants
- No sub-module. The next-state and output decode live in one module.

## Test plan
- Reset, then LDI (03) with `mem_ready`=1:
  - DECODE at cycle 2.
  - EXEC at cycle 3.
  - Cycle 4 has `a_wr`=1, `sel_A`=01.
  - FETCH at cycle 5.
- ADD (04) with `mem_ready` low for 3 EXEC cycles: `mem_rd`, `sel_B`=0 and `ula_op`=00 are held 4 cycles, then WB with `sel_A`=10.
- BEQ (08) with Z=1: EXEC has `pc_wr`=1, `pc_src`=1. With Z=0: `pc_wr`=0. Next state is FETCH in both cases.
- HLT (00): `halted`=1 from the cycle after DECODE. It stays 1 for 20 cycles, then clears on `reset`.
- Reset asserted during STO EXEC: `mem_wr` falls in the same cycle and the state is FETCH.
- With `CU_DEBUG_STEP_EN`: no `ir_wr` without `step`. One `step` pulse runs exactly one LDI.
